// File: rtl/counter_cmd_seq.sv
// rtl/counter_cmd_seq.sv - command FIFO and sequencer driving counter ld/inc/data_in
// Queued LOAD/INC_N/WAIT_N commands are expanded into registered per-cycle counter controls.
module counter_cmd_seq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [DATA_W-1:0]          cmd_data,
  input  logic [CNT_W-1:0]           cmd_cnt,
  output logic                       ld,
  output logic                       inc,
  output logic [DATA_W-1:0]          data_out,
  output logic                       busy,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int EW = 2 + DATA_W + CNT_W;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               ld_q, ld_d;
  logic               inc_q, inc_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic               ready_q;
  logic [EW-1:0]      mem_q [DEPTH];

  logic               push, pop;
  logic [EW-1:0]      head;
  logic [1:0]         head_op;
  logic [DATA_W-1:0]  head_data;
  logic [CNT_W-1:0]   head_cnt;

  assign head      = mem_q[rd_ptr_q];
  assign head_op   = head[EW-1 -: 2];
  assign head_data = head[CNT_W +: DATA_W];
  assign head_cnt  = head[CNT_W-1:0];

  // Ready comes from the registered occupancy, so a same-edge pop never frees a slot early.
  assign push = cmd_valid && ready_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ld_d    = 1'b0;
    inc_d   = inc_q;
    err_d   = 1'b0;
    data_d  = data_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        inc_d = 1'b0;
        pop   = (fill_q != '0);
      end
      S_EXEC: begin
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end else if (fill_q != '0) begin
          pop = 1'b1;
        end else begin
          state_d = S_IDLE;
          inc_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d = S_EXEC;
      inc_d   = 1'b0;
      rem_d   = (head_cnt == '0) ? '0 : head_cnt - CNT_W'(1);
      case (head_op)
        OP_LOAD: begin
          ld_d   = 1'b1;
          data_d = head_data;
          rem_d  = '0;
        end
        OP_INC:  inc_d = (head_cnt != '0);
        OP_WAIT: ;
        default: begin
          err_d = 1'b1;
          rem_d = '0;
        end
      endcase
    end

    fill_d = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + FW'(1);
    end else if (!push && pop) begin
      fill_d = fill_q - FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      ld_q     <= 1'b0;
      inc_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ld_q    <= ld_d;
      inc_q   <= inc_d;
      err_q   <= err_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      ready_q <= (fill_d != FULL);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {cmd_op, cmd_data, cmd_cnt};
  end

  assign cmd_ready = ready_q;
  assign ld        = ld_q;
  assign inc       = inc_q;
  assign err       = err_q;
  assign data_out  = data_q;
  assign fill      = fill_q;
  assign busy      = (state_q == S_EXEC) || (fill_q != '0);

endmodule
